// File: rtl/exec_writeback.sv
// exec_writeback
//   Commit stage that sits directly after the instruction decoder. It owns the
//   architectural A, D and PC registers and issues the *A memory write through
//   a req/ack handshake. While a write is outstanding, it stops accepting new
//   decoder results.
//
// Parameters
//   DATA_W  width of A, D, PC, decoder out, memory address and data
//   CNT_W   width of the saturating retired-instruction counter
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   instr_valid     decoder result valid this cycle
//   instr_ready     stage can accept a result (high only in EXEC)
//   dec_out         ALU/immediate value from decoder
//   dec_jmp         jump condition met
//   dec_dst         {A, D, *A} write enables
//   a_reg, d_reg    architectural A and D registers
//   pc              next fetch address
//   mem_wr_req      *A write request, held until acknowledged
//   mem_wr_addr     write address, stable while req is high
//   mem_wr_data     write data, stable while req is high
//   mem_wr_ack      memory accepted the write (ignored while req is low)
//   retired_cnt     accepted instruction count, saturating at all-ones
module exec_writeback #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] dec_out,
  input  logic              dec_jmp,
  input  logic [2:0]        dec_dst,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] d_reg,
  output logic [DATA_W-1:0] pc,
  output logic              mem_wr_req,
  output logic [DATA_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic {
    EXEC,
    WAIT_MEM
  } state_t;

  state_t state;

  // Ready depends only on state, so the decoder never sees a combinational
  // path from its own valid back into ready.
  assign instr_ready = (state == EXEC);

  // Single FSM block. In EXEC, an accepted result commits using the pre-edge
  // A value. Non-blocking semantics mean that a_reg on the right-hand side is
  // still A_old, so both the jump target and the *A address use the old A,
  // even when the same instruction rewrites A.
  // In WAIT_MEM, the write request and its address and data are frozen until
  // the memory acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EXEC;
      a_reg       <= '0;
      d_reg       <= '0;
      pc          <= '0;
      mem_wr_req  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      retired_cnt <= '0;
    end else begin
      case (state)
        EXEC: begin
          if (instr_valid) begin
            if (dec_dst[2]) a_reg <= dec_out;
            if (dec_dst[1]) d_reg <= dec_out;
            pc <= dec_jmp ? a_reg : pc + DATA_W'(1);
            if (dec_dst[0]) begin
              mem_wr_addr <= a_reg;
              mem_wr_data <= dec_out;
              mem_wr_req  <= 1'b1;
              state       <= WAIT_MEM;
            end
            if (retired_cnt != {CNT_W{1'b1}}) retired_cnt <= retired_cnt + CNT_W'(1);
          end
        end
        WAIT_MEM: begin
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            state      <= EXEC;
          end
        end
        default: state <= EXEC;
      endcase
    end
  end

endmodule
